fifo: RTL and testbench

FIFO -- requirements
Module: fifo

---
 rtl/fifo.sv | 101 ++++++++++
 tb/tb_fifo.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo.sv
// fifo: DEPTH-entry synchronous FIFO with registered read data and
// combinational EMPTY/FULL flags decoded from the occupancy count.
// Optional feature macro FIFO_BTN_EDGE_EN: when defined, write/read requests
// are the rising edges of BTN_WRITE/BTN_READ (one operation per press);
// when undefined, the buttons are level requests (one operation per cycle).
module fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] DATA_INPUT,
   input  logic                  BTN_WRITE,
   input  logic                  BTN_READ,
   output logic [DATA_WIDTH-1:0] DATA_OUT,
   output logic                  EMPTY,
   output logic                  FULL
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   // Count value meaning "DEPTH entries stored"
   localparam logic [ADDR_WIDTH:0] LP_FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic [DATA_WIDTH-1:0] r_data_out;

   logic w_wr_req;
   logic w_rd_req;
   logic w_wr_acc;
   logic w_rd_acc;
   logic w_empty;
   logic w_full;

`ifdef FIFO_BTN_EDGE_EN
   logic r_btn_wr_prev;
   logic r_btn_rd_prev;

   // Button history for rising-edge detection; cleared by reset so a button
   // already held at reset release counts as a fresh press.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_btn_wr_prev <= 1'b0;
         r_btn_rd_prev <= 1'b0;
      end else begin
         r_btn_wr_prev <= BTN_WRITE;
         r_btn_rd_prev <= BTN_READ;
      end
   end

   assign w_wr_req = BTN_WRITE & ~r_btn_wr_prev;
   assign w_rd_req = BTN_READ  & ~r_btn_rd_prev;
`else
   assign w_wr_req = BTN_WRITE;
   assign w_rd_req = BTN_READ;
`endif

   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == LP_FULL_CNT);
   // A read frees a slot in the same cycle, so a write on full is accepted
   // when paired with a read.
   assign w_rd_acc = w_rd_req & ~w_empty;
   assign w_wr_acc = w_wr_req & (~w_full | w_rd_acc);

   // Storage array; contents deliberately survive reset
   always_ff @(posedge CLK) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= DATA_INPUT;
      end
   end

   // Pointers, occupancy count and registered read data
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_data_out <= '0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_acc) begin
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_data_out <= r_mem[r_rd_ptr];
         end
         unique case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign DATA_OUT = r_data_out;
   assign EMPTY    = w_empty;
   assign FULL     = w_full;

endmodule

// File: tb/tb_fifo.sv
// tb_fifo: directed scenarios plus randomized traffic for fifo, checked
// against a queue-based reference model. Honours FIFO_BTN_EDGE_EN.
module tb_fifo;

   logic       CLK;
   logic       RST;
   logic [7:0] DATA_INPUT;
   logic       BTN_WRITE;
   logic       BTN_READ;
   logic [7:0] DATA_OUT;
   logic       EMPTY;
   logic       FULL;

   fifo #(
      .DATA_WIDTH (8),
      .ADDR_WIDTH (3)
   ) u_dut (
      .CLK        (CLK),
      .RST        (RST),
      .DATA_INPUT (DATA_INPUT),
      .BTN_WRITE  (BTN_WRITE),
      .BTN_READ   (BTN_READ),
      .DATA_OUT   (DATA_OUT),
      .EMPTY      (EMPTY),
      .FULL       (FULL)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference model state
   logic [7:0] m_q[$];
   logic [7:0] m_dout;
   logic       m_prev_w;
   logic       m_prev_r;

   int n_cmp;
   int n_err;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      check_val({tag, ".dout"},  {24'h0, DATA_OUT}, {24'h0, m_dout});
      check_val({tag, ".empty"}, {31'h0, EMPTY},    {31'h0, (m_q.size() == 0)});
      check_val({tag, ".full"},  {31'h0, FULL},     {31'h0, (m_q.size() == 8)});
   endtask

   // Drive one cycle of inputs, advance the model by one clock edge, compare.
   task automatic cycle(input logic wr, input logic rd, input logic [7:0] d);
      logic wreq, rreq, racc, wacc;
      BTN_WRITE  = wr;
      BTN_READ   = rd;
      DATA_INPUT = d;
      @(posedge CLK);
`ifdef FIFO_BTN_EDGE_EN
      wreq     = wr && !m_prev_w;
      rreq     = rd && !m_prev_r;
      m_prev_w = wr;
      m_prev_r = rd;
`else
      wreq = wr;
      rreq = rd;
`endif
      racc = rreq && (m_q.size() != 0);
      wacc = wreq && ((m_q.size() < 8) || racc);
      if (racc) m_dout = m_q.pop_front();
      if (wacc) m_q.push_back(d);
      #1;
      check_model("cyc");
   endtask

   task automatic wr_pulse(input logic [7:0] d);
      cycle(1'b1, 1'b0, d);
      cycle(1'b0, 1'b0, 8'h00);
   endtask

   task automatic rd_pulse();
      cycle(1'b0, 1'b1, 8'h00);
      cycle(1'b0, 1'b0, 8'h00);
   endtask

   // Assert reset between edges and check that outputs clear without a clock.
   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      #1;
      m_q.delete();
      m_dout   = 8'h00;
      m_prev_w = 1'b0;
      m_prev_r = 1'b0;
      check_val("rst.empty", {31'h0, EMPTY}, 32'd1);
      check_val("rst.full",  {31'h0, FULL},  32'd0);
      check_val("rst.dout",  {24'h0, DATA_OUT}, 32'h00);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   initial begin
      int n_held;
      n_cmp      = 0;
      n_err      = 0;
      RST        = 1'b0;
      BTN_WRITE  = 1'b0;
      BTN_READ   = 1'b0;
      DATA_INPUT = 8'h00;
      m_dout     = 8'h00;
      m_prev_w   = 1'b0;
      m_prev_r   = 1'b0;

      do_reset();

      // Four writes: not empty, not full, read data still at reset value
      wr_pulse(8'h01);
      check_val("w1.empty", {31'h0, EMPTY}, 32'd0);
      wr_pulse(8'h02);
      wr_pulse(8'h04);
      wr_pulse(8'h08);
      check_val("w4.full", {31'h0, FULL}, 32'd0);
      check_val("w4.dout", {24'h0, DATA_OUT}, 32'h00);

      rd_pulse();
      check_val("r1.dout", {24'h0, DATA_OUT}, 32'h01);
      rd_pulse();
      check_val("r2.dout", {24'h0, DATA_OUT}, 32'h02);
      wr_pulse(8'h10);
      wr_pulse(8'h20);
      rd_pulse();
      check_val("r3.dout", {24'h0, DATA_OUT}, 32'h04);
      rd_pulse();
      check_val("r4.dout", {24'h0, DATA_OUT}, 32'h08);
      rd_pulse();
      check_val("r5.dout", {24'h0, DATA_OUT}, 32'h10);
      rd_pulse();
      check_val("r6.dout", {24'h0, DATA_OUT}, 32'h20);
      check_val("r6.empty", {31'h0, EMPTY}, 32'd1);

      // Fill, overflow attempt, drain; twice to cross the pointer wrap
      for (int rep = 0; rep < 2; rep++) begin
         for (int i = 0; i < 8; i++) wr_pulse(8'hA0 + 8'(i));
         check_val("fill.full", {31'h0, FULL}, 32'd1);
         wr_pulse(8'hFF);
         check_val("ovf.full", {31'h0, FULL}, 32'd1);
         for (int i = 0; i < 8; i++) begin
            rd_pulse();
            check_val("drain.dout", {24'h0, DATA_OUT}, 32'(8'hA0 + 8'(i)));
         end
         check_val("drain.empty", {31'h0, EMPTY}, 32'd1);
      end

      // Read on empty holds the last data
      wr_pulse(8'h20);
      rd_pulse();
      rd_pulse();
      check_val("rdempty.dout", {24'h0, DATA_OUT}, 32'h20);
      check_val("rdempty.empty", {31'h0, EMPTY}, 32'd1);

      // Simultaneous read+write on empty: only the write takes effect
      cycle(1'b1, 1'b1, 8'h55);
      cycle(1'b0, 1'b0, 8'h00);
      check_val("rw_empty.empty", {31'h0, EMPTY}, 32'd0);
      check_val("rw_empty.dout", {24'h0, DATA_OUT}, 32'h20);
      rd_pulse();
      check_val("rw_empty.rd", {24'h0, DATA_OUT}, 32'h55);
      check_val("rw_empty.empty2", {31'h0, EMPTY}, 32'd1);

      // Simultaneous read+write on full: stays full
      for (int i = 0; i < 8; i++) wr_pulse(8'hC0 + 8'(i));
      cycle(1'b1, 1'b1, 8'hC8);
      cycle(1'b0, 1'b0, 8'h00);
      check_val("rw_full.full", {31'h0, FULL}, 32'd1);
      check_val("rw_full.dout", {24'h0, DATA_OUT}, 32'hC0);
      for (int i = 1; i < 9; i++) begin
         rd_pulse();
         check_val("rw_full.drain", {24'h0, DATA_OUT}, 32'(8'hC0 + 8'(i)));
      end

      // Button held for five cycles
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h33);
      cycle(1'b0, 1'b0, 8'h00);
`ifdef FIFO_BTN_EDGE_EN
      n_held = 1;
`else
      n_held = 5;
`endif
      for (int i = 0; i < n_held; i++) begin
         check_val("held.notempty", {31'h0, EMPTY}, 32'd0);
         rd_pulse();
         check_val("held.dout", {24'h0, DATA_OUT}, 32'h33);
      end
      check_val("held.empty", {31'h0, EMPTY}, 32'd1);

      // Asynchronous reset with three entries stored
      wr_pulse(8'h11);
      wr_pulse(8'h22);
      wr_pulse(8'h33);
      rd_pulse();
      do_reset();
      rd_pulse();
      check_val("postrst.dout", {24'h0, DATA_OUT}, 32'h00);

      // Write already requested at reset release is honoured on the first edge
      BTN_WRITE  = 1'b1;
      DATA_INPUT = 8'h77;
      do_reset();
      cycle(1'b1, 1'b0, 8'h77);
      cycle(1'b0, 1'b0, 8'h00);
      rd_pulse();
      check_val("relheld.dout", {24'h0, DATA_OUT}, 32'h77);

      // Randomized traffic with shifting read/write bias and rare resets
      for (int ph = 0; ph < 6; ph++) begin
         int wp;
         int rp;
         wp = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 20 : 50);
         rp = 100 - wp;
         for (int i = 0; i < 400; i++) begin
            if ($urandom_range(299) == 0) begin
               do_reset();
            end else begin
               cycle(($urandom_range(99) < wp), ($urandom_range(99) < rp), 8'($urandom));
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
